neuron_accumulator: RTL and testbench

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

---
 rtl/neuron_accumulator.sv | 121 ++++++++++++
 tb/tb_neuron_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums N_INPUTS signed products, adds a bias, optionally applies ReLU.
// Define NEURON_ACC_SAT_EN to saturate every add; otherwise adds wrap modulo 2^22.
module neuron_accumulator #(
    parameter int N_INPUTS = 784,
    parameter int RELU     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [19:0] in_prod,
    input  logic signed [21:0] bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [21:0] out_data,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and an offered value is held stable until it transfers.

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_BIAS  = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam logic [9:0]         LAST_CNT = 10'(N_INPUTS - 1);
    localparam logic signed [21:0] SAT_MAX  = 22'sh1FFFFF;
    localparam logic signed [21:0] SAT_MIN  = 22'sh200000;

    state_t             r_state;
    state_t             w_next_state;
    logic signed [21:0] r_acc;
    logic signed [21:0] r_res;
    logic [9:0]         r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_out_done;
    logic signed [21:0] w_prod_ext;
    logic signed [21:0] w_sum;
    logic signed [21:0] w_biased;
    logic signed [21:0] w_res_next;

`ifdef NEURON_ACC_SAT_EN
    function automatic logic signed [21:0] add22(input logic signed [21:0] a,
                                                  input logic signed [21:0] b);
        logic signed [22:0] s;
        s = {a[21], a} + {b[21], b};
        if (s[22] != s[21]) begin
            return s[22] ? SAT_MIN : SAT_MAX;
        end
        return s[21:0];
    endfunction
`else
    function automatic logic signed [21:0] add22(input logic signed [21:0] a,
                                                  input logic signed [21:0] b);
        return a + b;
    endfunction
`endif

    assign w_accept   = in_valid && (r_state == S_ACCUM);
    assign w_last     = w_accept && (r_cnt == LAST_CNT);
    assign w_out_done = (r_state == S_OUT) && out_ready;
    assign w_prod_ext = {{2{in_prod[19]}}, in_prod};
    assign w_sum      = add22(r_acc, w_prod_ext);
    assign w_biased   = add22(r_acc, bias);
    assign w_res_next = ((RELU != 0) && w_biased[21]) ? 22'sd0 : w_biased;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ACCUM: if (w_last) w_next_state = S_BIAS;
            S_BIAS:  w_next_state = S_OUT;
            S_OUT:   if (out_ready) w_next_state = S_ACCUM;
            default: w_next_state = S_ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_ACCUM);
        out_valid = (r_state == S_OUT);
        busy      = (r_cnt != 10'd0) || (r_state != S_ACCUM);
        out_data  = r_res;
        dbg_state = r_state;
    end

    // The accumulator is cleared only when the result leaves, so bubbles never disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
            end else if (w_out_done) begin
                r_acc <= '0;
            end
            if (w_last) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 10'd1;
            end
            if (r_state == S_BIAS) begin
                r_res <= w_res_next;
            end
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: two instances (ReLU on / off) share one stimulus stream,
// checked each cycle against a transaction-level model plus literal expectations.
module tb_neuron_accumulator;

    localparam int N = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [19:0] in_prod;
    logic signed [21:0] bias;
    logic               out_ready;

    logic               in_ready,  in_ready_nr;
    logic               out_valid, out_valid_nr;
    logic signed [21:0] out_data,  out_data_nr;
    logic               busy,      busy_nr;
    logic [1:0]         dbg_state, dbg_state_nr;

    int checks   = 0;
    int failures = 0;

    neuron_accumulator #(.N_INPUTS(N), .RELU(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .dbg_state(dbg_state)
    );

    neuron_accumulator #(.N_INPUTS(N), .RELU(0)) u_dut_nr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nr),
        .in_prod(in_prod), .bias(bias), .out_valid(out_valid_nr), .out_ready(out_ready),
        .out_data(out_data_nr), .busy(busy_nr), .dbg_state(dbg_state_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a neuron is a list of N accepted beats; result = sum + bias with 22-bit rules.
    function automatic int m_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef NEURON_ACC_SAT_EN
        if (s > 2097151) s = 2097151;
        else if (s < -2097152) s = -2097152;
`else
        if (s > 2097151) s -= 4194304;
        else if (s < -2097152) s += 4194304;
`endif
        return s;
    endfunction

    int m_acc, m_cnt, m_res, m_res_nr, m_delay;
    bit m_have;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_have = 0; m_delay = 0; m_res = 0; m_res_nr = 0;
        end else if (m_have && m_delay == 0) begin
            if (out_ready) begin
                m_have = 0;
                m_acc  = 0;
            end
        end else if (m_have) begin
            m_delay--;
        end else if (in_valid) begin
            m_acc = m_add(m_acc, int'(in_prod));
            m_cnt++;
            if (m_cnt == N) begin
                m_cnt    = 0;
                m_have   = 1;
                m_delay  = 1;
                m_res_nr = m_add(m_acc, int'(bias));
                m_res    = (m_res_nr < 0) ? 0 : m_res_nr;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready", int'(in_ready), int'(!m_have));
            chk("m_out_valid", int'(out_valid), int'(m_have && m_delay == 0));
            chk("m_busy", int'(busy), int'(m_cnt != 0 || m_have));
            chk("m_state_pair", int'(dbg_state_nr), int'(dbg_state));
            if (m_have && m_delay == 0) begin
                chk("m_out_data", int'(out_data), m_res);
                chk("m_out_data_nr", int'(out_data_nr), m_res_nr);
            end
        end
    end

    task automatic send_beat(input int p, input int bubbles);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_prod  = 20'(p);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("beat_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (bubbles) @(negedge clk);
    endtask

    task automatic wait_out();
        int guard;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("out_timeout", 0, 1);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] held_state;
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; bias = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);

        // 100 - 30 + 7 + 23 - 50 = 50; one bias cycle, then the result
        bias = -22'sd50;
        send_beat(100, 0); send_beat(-30, 0); send_beat(7, 0); send_beat(23, 0);
        chk("lat_bias_cycle_valid", int'(out_valid), 0);
        chk("lat_bias_cycle_busy", int'(busy), 1);
        @(negedge clk);
        chk("lat_out_valid", int'(out_valid), 1);
        chk("t1_out_data", int'(out_data), 50);
        chk("t1_out_data_nr", int'(out_data_nr), 50);
        take_out();

        // 40 - 100 = -60: ReLU clamps to 0, plain build keeps -60
        bias = -22'sd100;
        for (int i = 0; i < N; i++) send_beat(10, 2);
        wait_out();
        chk("t2_relu", int'(out_data), 0);
        chk("t2_norelu", int'(out_data_nr), -60);
        take_out();

        // Backpressure: result 10 held; the waiting beat 99 is not consumed until release
        bias = '0;
        send_beat(1, 0); send_beat(2, 0); send_beat(3, 0); send_beat(4, 0);
        wait_out();
        held_state = dbg_state;
        in_valid = 1'b1;
        in_prod  = 20'sd99;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), 10);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_state", int'(dbg_state), int'(held_state));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        send_beat(1, 0); send_beat(1, 0); send_beat(1, 0);
        wait_out();
        chk("t3_next_neuron", int'(out_data), 102);
        take_out();

        // 4 * 524287 + 1000000 = 3097148 exceeds the 22-bit range
        bias = 22'sd1000000;
        for (int i = 0; i < N; i++) send_beat(524287, 0);
        wait_out();
`ifdef NEURON_ACC_SAT_EN
        chk("t4_sat", int'(out_data), 2097151);
        chk("t4_sat_nr", int'(out_data_nr), 2097151);
`else
        chk("t4_wrap", int'(out_data), 0);
        chk("t4_wrap_nr", int'(out_data_nr), -1097156);
`endif
        take_out();

        // Asynchronous reset mid-stream discards the two beats already taken
        bias = '0;
        send_beat(5, 0); send_beat(5, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_out_data_nr", int'(out_data_nr), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < N; i++) send_beat(1, 0);
        wait_out();
        chk("t5_fresh", int'(out_data), 4);
        chk("t5_fresh_nr", int'(out_data_nr), 4);
        take_out();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
